// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - FSM states and result encoding for the serial comparator
package comparator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Result bits map directly onto {AgtB, AltB, AeqB}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/digit_compare.sv
// rtl/digit_compare.sv - combinational unsigned compare of one DIGIT-bit slice
module digit_compare #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - MSB-first digit-serial magnitude comparator with early exit
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              is_signed,
  input  logic [WIDTH-1:0]                  A,
  input  logic [WIDTH-1:0]                  B,
  output logic                              busy,
  output logic                              done,
  output logic                              AgtB,
  output logic                              AltB,
  output logic                              AeqB,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]  cycles
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_comparator: WIDTH must be 2..64 and a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;
  logic             dig_gt, dig_lt;
  logic [WIDTH-1:0] sign_mask;

  // Flipping both sign bits once at load turns a signed compare into an unsigned one
  assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    res_d    = res_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A ^ sign_mask;
          b_d     = B ^ sign_mask;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (dig_gt || dig_lt) begin
          res_d    = dig_gt ? RES_GT : RES_LT;
          cycles_d = cnt_q + 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == CW'(N - 1)) begin
          res_d    = RES_EQ;
          cycles_d = cnt_q + 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      res_q    <= RES_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign busy               = (state_q == ST_RUN);
  assign done               = done_q;
  assign {AgtB, AltB, AeqB} = res_q;
  assign cycles             = cycles_q;

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - self-checking bench for serial_comparator (DIGIT=1 and DIGIT=4)
module tb_serial_comparator;

  localparam logic [2:0] EXP_GT = 3'b100;
  localparam logic [2:0] EXP_LT = 3'b010;
  localparam logic [2:0] EXP_EQ = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, gt8, lt8, eq8;
  logic [3:0] cyc8;

  logic       start4 = 1'b0, sgn4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, gt4, lt4, eq4;
  logic [1:0] cyc4;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_comparator #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .AgtB(gt8), .AltB(lt8), .AeqB(eq8), .cycles(cyc8)
  );

  serial_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .AgtB(gt4), .AltB(lt4), .AeqB(eq4), .cycles(cyc4)
  );

  function automatic logic [2:0] flags_of(input bit sel);
    return sel ? {gt4, lt4, eq4} : {gt8, lt8, eq8};
  endfunction
  function automatic int cyc_of(input bit sel);
    return sel ? int'(cyc4) : int'(cyc8);
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy4 : busy8;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done4 : done8;
  endfunction

  // Reference: true numeric ordering, plus index of the first differing digit from the top
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                input int d, output logic [2:0] f, output int c);
    int         n;
    bit         found;
    longint     sa, sb;
    logic [7:0] da, db, mask;
    n     = 8 / d;
    c     = n;
    found = 0;
    mask  = 8'((1 << d) - 1);
    for (int k = 1; k <= n; k++) begin
      da = (a >> (8 - k * d)) & mask;
      db = (b >> (8 - k * d)) & mask;
      if (!found && da != db) begin
        c     = k;
        found = 1;
      end
    end
    sa = s ? longint'($signed(a)) : longint'({56'b0, a});
    sb = s ? longint'($signed(b)) : longint'({56'b0, b});
    f  = (sa > sb) ? EXP_GT : ((sa < sb) ? EXP_LT : EXP_EQ);
  endfunction

  task automatic run_cmp(input bit sel, input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [2:0] flags, output int cyc, output int lat,
                         output int busy_n, output bit hold_ok, output bit got_done);
    logic [2:0] prev_f;
    int         prev_c;
    prev_f = flags_of(sel);
    prev_c = cyc_of(sel);
    @(negedge clk);
    if (sel) begin a4 = a; b4 = b; sgn4 = s; start4 = 1'b1; end
    else     begin a8 = a; b8 = b; sgn8 = s; start8 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    lat = 0; busy_n = 0; hold_ok = 1; got_done = 0;
    while (lat < 40 && !got_done) begin
      if (busy_of(sel)) busy_n++;
      if (flags_of(sel) !== prev_f || cyc_of(sel) !== prev_c) hold_ok = 0;
      @(negedge clk);
      lat++;
      got_done = done_of(sel);
    end
    flags = flags_of(sel);
    cyc   = cyc_of(sel);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, gt8, lt8, eq8, cyc8} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_dut8 outputs=%b required=000000000", {busy8, done8, gt8, lt8, eq8, cyc8});
    end
    tests_run++;
    if ({busy4, done4, gt4, lt4, eq4, cyc4} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_dut4 outputs=%b required=0000000", {busy4, done4, gt4, lt4, eq4, cyc4});
    end
    start8 = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy8, done8, gt8, lt8, eq8, cyc8} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_held outputs=%b required=000000000", {busy8, done8, gt8, lt8, eq8, cyc8});
    end
    start8 = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       ts [4];
    logic [2:0] tf [4];
    int         tc [4];
    logic [2:0] f;
    int         c, lat, bn;
    bit         hold_ok, got;
    ta = '{8'h00, 8'h80, 8'h80, 8'h05};
    tb = '{8'h00, 8'h7F, 8'h7F, 8'h03};
    ts = '{1'b0, 1'b0, 1'b1, 1'b0};
    tf = '{EXP_EQ, EXP_GT, EXP_LT, EXP_GT};
    tc = '{8, 1, 1, 6};
    for (int i = 0; i < 4; i++) begin
      run_cmp(1'b0, ta[i], tb[i], ts[i], f, c, lat, bn, hold_ok, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL directed%0d_done timed out after %0d cycles", i, lat);
      end
      tests_run++;
      if (f !== tf[i]) begin
        tests_failed++;
        $display("FAIL directed%0d_flags got=%b required=%b", i, f, tf[i]);
      end
      tests_run++;
      if (c !== tc[i] || lat !== tc[i]) begin
        tests_failed++;
        $display("FAIL directed%0d_cycles cycles=%0d latency=%0d required=%0d", i, c, lat, tc[i]);
      end
      tests_run++;
      if (bn !== tc[i] || busy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed%0d_busy busy_cycles=%0d busy_at_done=%b required=%0d/0", i, bn, busy8, tc[i]);
      end
      @(negedge clk);
      tests_run++;
      if (done8 !== 1'b0 || f !== {gt8, lt8, eq8}) begin
        tests_failed++;
        $display("FAIL directed%0d_pulse done=%b flags=%b required done=0 flags=%b", i, done8, {gt8, lt8, eq8}, f);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; sgn8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 2;
    while (lat < 40 && done8 !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if ({gt8, lt8, eq8} !== EXP_GT || cyc8 !== 4'd6 || lat !== 6) begin
      tests_failed++;
      $display("FAIL ignore_start flags=%b cycles=%0d latency=%0d required=%b/6/6", {gt8, lt8, eq8}, cyc8, lat, EXP_GT);
    end
    @(negedge clk);
    tests_run++;
    if (busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_start_relatch busy=%b required=0", busy8);
    end
  endtask

  task automatic test_reset_abort();
    bit         saw_done, hold_ok, got;
    logic [2:0] f;
    int         c, lat, bn;
    saw_done = 0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; sgn8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_done |= done8;
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, gt8, lt8, eq8, cyc8} !== 9'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs got=%b required=000000000", {busy8, done8, gt8, lt8, eq8, cyc8});
    end
    repeat (2) begin
      @(negedge clk);
      saw_done |= done8;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done |= done8;
    end
    tests_run++;
    if (saw_done) begin
      tests_failed++;
      $display("FAIL abort_no_done done pulse seen=1 required=0");
    end
    run_cmp(1'b0, 8'h01, 8'h02, 1'b0, f, c, lat, bn, hold_ok, got);
    tests_run++;
    if (!got || f !== EXP_LT || c !== 7 || lat !== 7) begin
      tests_failed++;
      $display("FAIL abort_restart done=%b flags=%b cycles=%0d latency=%0d required=1/%b/7/7", got, f, c, lat, EXP_LT);
    end
  endtask

  task automatic test_digit4();
    logic [2:0] f;
    int         c, lat, bn;
    bit         hold_ok, got;
    run_cmp(1'b1, 8'h3C, 8'h3F, 1'b0, f, c, lat, bn, hold_ok, got);
    tests_run++;
    if (!got || f !== EXP_LT || c !== 2 || lat !== 2 || bn !== 2) begin
      tests_failed++;
      $display("FAIL digit4_3c_3f done=%b flags=%b cycles=%0d latency=%0d busy=%0d required=1/%b/2/2/2", got, f, c, lat, bn, EXP_LT);
    end
    run_cmp(1'b1, 8'h80, 8'h7F, 1'b1, f, c, lat, bn, hold_ok, got);
    tests_run++;
    if (!got || f !== EXP_LT || c !== 1 || lat !== 1) begin
      tests_failed++;
      $display("FAIL digit4_signed done=%b flags=%b cycles=%0d latency=%0d required=1/%b/1/1", got, f, c, lat, EXP_LT);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       s;
    bit         sel, hold_ok, got;
    logic [2:0] f, ef;
    int         c, ec, lat, bn;
    for (int i = 0; i < 60; i++) begin
      sel = bit'($urandom_range(0, 1));
      s   = logic'($urandom_range(0, 1));
      a   = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       b = 8'($urandom);
        1:       b = a;
        default: b = a ^ (8'h01 << $urandom_range(0, 7));
      endcase
      model(a, b, s, sel ? 4 : 1, ef, ec);
      run_cmp(sel, a, b, s, f, c, lat, bn, hold_ok, got);
      tests_run++;
      if (!got || f !== ef) begin
        tests_failed++;
        $display("FAIL random%0d_flags d%0d a=%h b=%h s=%b done=%b got=%b required=%b", i, sel ? 4 : 1, a, b, s, got, f, ef);
      end
      tests_run++;
      if (c !== ec || lat !== ec || bn !== ec) begin
        tests_failed++;
        $display("FAIL random%0d_cycles a=%h b=%h cycles=%0d latency=%0d busy=%0d required=%0d", i, a, b, c, lat, bn, ec);
      end
      tests_run++;
      if (!hold_ok) begin
        tests_failed++;
        $display("FAIL random%0d_hold result changed while busy got=1 required=0", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [4];
    logic [7:0] ob [4];
    logic       os [4];
    logic [2:0] ef;
    int         ec, lat;
    for (int k = 0; k < 4; k++) begin
      oa[k] = 8'($urandom);
      ob[k] = (k == 1) ? oa[k] : 8'($urandom);
      os[k] = logic'($urandom_range(0, 1));
    end
    @(negedge clk);
    a8 = oa[0]; b8 = ob[0]; sgn8 = os[0]; start8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (busy8 !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b%0d_start busy=%b required=1", k, busy8);
      end
      lat = 0;
      while (lat < 40 && done8 !== 1'b1) begin
        @(negedge clk);
        lat++;
      end
      model(oa[k], ob[k], os[k], 1, ef, ec);
      tests_run++;
      if ({gt8, lt8, eq8} !== ef || cyc8 !== 4'(ec) || lat !== ec || busy8 !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b%0d_result flags=%b cycles=%0d latency=%0d busy=%b required=%b/%0d/%0d/0", k, {gt8, lt8, eq8}, cyc8, lat, busy8, ef, ec, ec);
      end
      if (k < 3) begin
        a8 = oa[k+1]; b8 = ob[k+1]; sgn8 = os[k+1];
      end
    end
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_digit4();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
